// File: rtl/pipe_event_monitor.sv
// Performance monitor: counts RUN cycles and per-channel pipeline events under
// start/freeze/clear control, with an automatic stop and a registered read port.
module pipe_event_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30,
    parameter int WRAP_MODE   = 0,
    parameter int SEL_W       = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              freeze_i,
    input  logic              clear_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              rd_req_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic              done_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CYCLE_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CNT_W-1:0] cycle_next;
    logic [CNT_W-1:0] sel_value;

    // Overflow policy shared by the channel counters and the cycle counter.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return (WRAP_MODE != 0) ? '0 : CNT_MAX;
        end
        return value + 1'b1;
    endfunction

    assign cycle_next = bump(cycle_o);
    assign state_o    = state;

    always_comb begin
        sel_value = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel_i == SEL_W'(k)) begin
                sel_value = cnt[k];
            end
        end
    end

    // NOTE: the counter array is reset along with the rest of the state because
    // every count must read back as zero straight out of reset; it is small
    // enough to live in flops rather than a RAM.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cycle_o <= '0;
            ovf_o   <= '0;
            done_o  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
            end
        end else if (clear_i) begin
            state   <= IDLE;
            cycle_o <= '0;
            ovf_o   <= '0;
            done_o  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) state <= RUN;
                end
                RUN: begin
                    if (!start_i) begin
                        state <= IDLE;
                    end else if (freeze_i) begin
                        state <= FROZEN;
                    end else begin
                        cycle_o <= cycle_next;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (event_i[k]) begin
                                cnt[k] <= bump(cnt[k]);
                                if (cnt[k] == CNT_MAX) ovf_o[k] <= 1'b1;
                            end
                        end
                        // The final cycle's events still count; the stop takes effect next edge.
                        if (CYCLE_LIMIT != 0 && cycle_next == LIMIT) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                FROZEN: begin
                    if (!start_i) begin
                        state <= IDLE;
                    end else if (!freeze_i) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments here sample cnt before this edge's increment,
    // which is exactly the pre-update value a coincident read must return.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= sel_value;
            end
        end
    end

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Bench for pipe_event_monitor: three configurations share one stimulus stream
// and are compared every cycle against an integer reference model.
module tb_pipe_event_monitor;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i, freeze_i, clear_i, rd_req_i;
    logic [3:0] event_i;
    logic [2:0] rd_sel_i;

    logic [31:0] rd0, cy0;
    logic [3:0]  rd1, cy1, rd2, cy2;
    logic [3:0]  ov0, ov1, ov2;
    logic [1:0]  st0, st1, st2;
    logic        rv0, rv1, rv2, dn0, dn1, dn2;

    logic [31:0] d_rd [3];
    logic [31:0] d_cyc [3];
    logic [3:0]  d_ovf [3];
    logic [1:0]  d_st [3];
    logic        d_rv [3];
    logic        d_done [3];

    assign d_rd[0] = rd0;            assign d_rd[1] = {28'b0, rd1};  assign d_rd[2] = {28'b0, rd2};
    assign d_cyc[0] = cy0;           assign d_cyc[1] = {28'b0, cy1}; assign d_cyc[2] = {28'b0, cy2};
    assign d_ovf[0] = ov0;           assign d_ovf[1] = ov1;          assign d_ovf[2] = ov2;
    assign d_st[0] = st0;            assign d_st[1] = st1;           assign d_st[2] = st2;
    assign d_rv[0] = rv0;            assign d_rv[1] = rv1;           assign d_rv[2] = rv2;
    assign d_done[0] = dn0;          assign d_done[1] = dn1;         assign d_done[2] = dn2;

    always #5 clk = ~clk;

    pipe_event_monitor #(.NUM_CH(4), .CNT_W(32), .CYCLE_LIMIT(30), .WRAP_MODE(0), .SEL_W(3)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i), .clear_i(clear_i),
        .event_i(event_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_valid_o(rv0),
        .rd_data_o(rd0), .cycle_o(cy0), .ovf_o(ov0), .done_o(dn0), .state_o(st0));

    pipe_event_monitor #(.NUM_CH(4), .CNT_W(4), .CYCLE_LIMIT(0), .WRAP_MODE(0), .SEL_W(3)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i), .clear_i(clear_i),
        .event_i(event_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_valid_o(rv1),
        .rd_data_o(rd1), .cycle_o(cy1), .ovf_o(ov1), .done_o(dn1), .state_o(st1));

    pipe_event_monitor #(.NUM_CH(4), .CNT_W(4), .CYCLE_LIMIT(0), .WRAP_MODE(1), .SEL_W(3)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .freeze_i(freeze_i), .clear_i(clear_i),
        .event_i(event_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_valid_o(rv2),
        .rd_data_o(rd2), .cycle_o(cy2), .ovf_o(ov2), .done_o(dn2), .state_o(st2));

    // Reference model: plain integers, one slot per configuration.
    int     cfg_w    [3] = '{32, 4, 4};
    int     cfg_lim  [3] = '{30, 0, 0};
    int     cfg_wrap [3] = '{0, 0, 1};
    longint m_cnt [3][4];
    longint m_cyc [3];
    longint m_rd  [3];
    bit [3:0] m_ovf [3];
    int     m_st  [3];
    bit     m_done [3];
    bit     m_rv  [3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
            m_cyc[i] = 0; m_rd[i] = 0; m_ovf[i] = '0;
            m_st[i] = 0; m_done[i] = 0; m_rv[i] = 0;
        end
    endtask

    // Next value under the overflow rule; sets ovf when the counter was at its maximum.
    task automatic model_inc(input int i, input longint v, output longint nv, output bit ovf);
        longint range;
        range = longint'(1) << cfg_w[i];
        nv = v + 1;
        ovf = 1'b0;
        if (nv >= range) begin
            ovf = 1'b1;
            nv = (cfg_wrap[i] != 0) ? nv % range : range - 1;
        end
    endtask

    task automatic model_step();
        longint nv;
        bit     o;
        int     sel;
        sel = int'(rd_sel_i);
        for (int i = 0; i < 3; i++) begin
            m_rv[i] = rd_req_i;
            if (rd_req_i) m_rd[i] = (sel < 4) ? m_cnt[i][sel] : 0;
            if (clear_i) begin
                for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
                m_cyc[i] = 0; m_ovf[i] = '0; m_done[i] = 0; m_st[i] = 0;
            end else if (m_st[i] == 0) begin
                if (start_i) m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                if (!start_i) m_st[i] = 0;
                else if (freeze_i) m_st[i] = 2;
                else begin
                    model_inc(i, m_cyc[i], nv, o);
                    m_cyc[i] = nv;
                    for (int k = 0; k < 4; k++) begin
                        if (event_i[k]) begin
                            model_inc(i, m_cnt[i][k], nv, o);
                            m_cnt[i][k] = nv;
                            if (o) m_ovf[i][k] = 1'b1;
                        end
                    end
                    if (cfg_lim[i] != 0 && m_cyc[i] == longint'(cfg_lim[i])) begin
                        m_st[i] = 3; m_done[i] = 1;
                    end
                end
            end else if (m_st[i] == 2) begin
                if (!start_i) m_st[i] = 0;
                else if (!freeze_i) m_st[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d_state", i), 64'(d_st[i]), 64'(m_st[i]));
            check($sformatf("i%0d_cycle", i), 64'(d_cyc[i]), 64'(m_cyc[i]));
            check($sformatf("i%0d_ovf", i), 64'(d_ovf[i]), 64'(m_ovf[i]));
            check($sformatf("i%0d_done", i), 64'(d_done[i]), 64'(m_done[i]));
            check($sformatf("i%0d_rd_valid", i), 64'(d_rv[i]), 64'(m_rv[i]));
            check($sformatf("i%0d_rd_data", i), 64'(d_rd[i]), 64'(m_rd[i]));
        end
    endtask

    task automatic step(input int n = 1);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    task automatic read_ch(input int sel);
        rd_req_i = 1'b1;
        rd_sel_i = 3'(sel);
        step();
        rd_req_i = 1'b0;
    endtask

    logic [31:0] v0, v1, v2;

    initial begin
        rst_i = 1'b0; start_i = 1'b0; freeze_i = 1'b0; clear_i = 1'b0;
        event_i = '0; rd_req_i = 1'b0; rd_sel_i = '0;
        model_reset();
        #12;
        compare_all();
        rst_i = 1'b1;

        // Run to the cycle limit with events on channel 0.
        start_i = 1'b1; event_i = 4'b0001;
        step(31);
        check("t1_done", 64'(dn0), 64'd1);
        check("t1_cycle", 64'(cy0), 64'd30);
        check("t1_state", 64'(st0), 64'd3);
        event_i = '0;
        for (int k = 0; k < 4; k++) begin
            read_ch(k);
            check($sformatf("t1_ch%0d", k), 64'(rd0), (k == 0) ? 64'd30 : 64'd0);
        end

        // Freeze holds counters even with events asserted.
        clear_i = 1'b1; step(); clear_i = 1'b0;
        event_i = 4'b0010;
        step(11);
        freeze_i = 1'b1; step(5);
        freeze_i = 1'b0; step(4);
        event_i = '0; start_i = 1'b0; step();
        read_ch(1);
        check("t2_ch1", 64'(rd0), 64'd13);
        check("t2_cycle", 64'(cy0), 64'd13);

        // Saturate vs wrap on 4-bit counters.
        clear_i = 1'b1; step(); clear_i = 1'b0;
        start_i = 1'b1; event_i = 4'b0100;
        step(21);
        start_i = 1'b0; event_i = '0; step();
        read_ch(2);
        check("t3_sat_ch2", 64'(rd1), 64'd15);
        check("t3_wrap_ch2", 64'(rd2), 64'd4);
        check("t3_sat_ovf2", 64'(ov1[2]), 64'd1);
        check("t3_wrap_ovf2", 64'(ov2[2]), 64'd1);

        // Back-to-back reads during counting, then an out-of-range select.
        clear_i = 1'b1; step(); clear_i = 1'b0;
        start_i = 1'b1; event_i = 4'b0001;
        step(6);
        rd_req_i = 1'b1; rd_sel_i = 3'd0;
        step(); v0 = rd0;
        step(); v1 = rd0;
        step(); v2 = rd0;
        check("t4_v0", 64'(v0), 64'd5);
        check("t4_v1", 64'(v1), 64'(v0) + 64'd1);
        check("t4_v2", 64'(v2), 64'(v0) + 64'd2);
        rd_sel_i = 3'd7; step();
        check("t4_oob_data", 64'(rd0), 64'd0);
        check("t4_oob_valid", 64'(rv0), 64'd1);
        rd_req_i = 1'b0; step();
        check("t4_valid_drop", 64'(rv0), 64'd0);

        // Clear with start held, plus a coincident read returning the pre-clear value.
        clear_i = 1'b1; step(); clear_i = 1'b0;
        step(13);
        clear_i = 1'b1; rd_req_i = 1'b1; rd_sel_i = 3'd0;
        step();
        clear_i = 1'b0; rd_req_i = 1'b0;
        check("t5_read_preclear", 64'(rd0), 64'd12);
        check("t5_state", 64'(st0), 64'd0);
        check("t5_cycle", 64'(cy0), 64'd0);
        step();
        check("t5_state_run", 64'(st0), 64'd1);
        check("t5_cycle_hold", 64'(cy0), 64'd0);
        step();
        check("t5_cycle_first", 64'(cy0), 64'd1);

        // Randomised traffic across all states.
        for (int n = 0; n < 400; n++) begin
            start_i  = ($urandom_range(0, 9) != 0);
            freeze_i = ($urandom_range(0, 4) == 0);
            clear_i  = ($urandom_range(0, 39) == 0);
            event_i  = 4'($urandom);
            rd_req_i = 1'($urandom);
            rd_sel_i = 3'($urandom_range(0, 7));
            step();
        end

        // Asynchronous reset between edges mid-RUN.
        start_i = 1'b1; freeze_i = 1'b0; rd_req_i = 1'b0; event_i = 4'b1111;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        step(4);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t6_state_async", 64'(st0), 64'd0);
        check("t6_cycle_async", 64'(cy0), 64'd0);
        #1 rst_i = 1'b1;
        start_i = 1'b0;
        step(2);
        check("t6_idle_after", 64'(st0), 64'd0);
        start_i = 1'b1;
        step();
        check("t6_run_after", 64'(st0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_event_monitor.md
Name: pipe_event_monitor

Overview:
Synthesizable performance-monitor block for the pipelined CPU. It counts clock cycles and NUM_CH pipeline event streams, such as stalls, flushes and retired instructions, under start/freeze/clear control. It stops automatically after a programmable cycle limit and provides a registered read port for per-channel counts. It sits beside the CPU core and is the hardware counterpart of the bench-side stall/flush counting.

Parameters:
NUM_CH, 4, number of event channels (1..16)
CNT_W, 32, width of every channel counter and of the cycle counter
CYCLE_LIMIT, 30, RUN cycles before automatic stop; 0 = no limit
WRAP_MODE, 0, counter overflow handling: 0 = saturate at all-ones, 1 = wrap to zero
SEL_W, 2, width of rd_sel_i; must be >= clog2(NUM_CH), minimum 1

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  level enable: counting runs while high
freeze_i  in  1  hold all counters while high (RUN only)
clear_i  in  1  synchronous clear of all counters and flags
event_i  in  NUM_CH  per-channel event pulse, 1 = count this cycle
rd_req_i  in  1  read request, sampled each edge
rd_sel_i  in  SEL_W  channel index to read
rd_valid_o  out  1  read data valid, one-cycle pulse
rd_data_o  out  CNT_W  counter value returned by the read
cycle_o  out  CNT_W  RUN-cycle count
ovf_o  out  NUM_CH  sticky per-channel overflow flag
done_o  out  1  cycle limit reached
state_o  out  2  current state: 0 IDLE, 1 RUN, 2 FROZEN, 3 DONE

Behaviour:
Reset
- rst_i low: asynchronous reset to state IDLE.
- All counters, cycle_o, ovf_o, rd_data_o, rd_valid_o and done_o are 0.

State machine (evaluated each edge; priority order top to bottom)
- clear_i=1 in any state: zero all counters, cycle_o and ovf_o; done_o=0; go to IDLE. A simultaneous start_i is ignored that cycle.
- IDLE: start_i=1 -> RUN. Counting begins on the next edge, not on the transition edge.
- RUN, start_i=0: -> IDLE. Counter values are held.
- RUN, freeze_i=1: -> FROZEN. No increment on this edge.
- RUN otherwise: cycle counter +1; channel k +1 if event_i[k]=1.
- RUN, incremented cycle value == CYCLE_LIMIT (CYCLE_LIMIT != 0): -> DONE on the same edge, done_o=1. Events in that final cycle are counted.
- FROZEN: freeze_i=0 -> RUN; start_i=0 -> IDLE (start_i takes priority over freeze_i). Counters hold.
- DONE: hold all values until clear_i or reset. start_i and freeze_i are ignored.

Arithmetic and overflow
- Counters are unsigned, CNT_W bits.
- Channel counter at all-ones with an event, WRAP_MODE=0: stays all-ones, ovf_o[k] set.
- Same condition, WRAP_MODE=1: counter goes to 0, ovf_o[k] set.
- ovf_o is sticky; only clear_i or reset clears it.
- The cycle counter follows the same WRAP_MODE rule but has no flag.

Read port
- rd_req_i sampled at edge N.
- At edge N+1: rd_valid_o=1 and rd_data_o holds the channel value as it was before any increment at edge N.
- rd_valid_o drops to 0 the cycle after unless another request is made.
- Back-to-back requests are allowed, one result per cycle.
- rd_sel_i >= NUM_CH: rd_valid_o=1 and rd_data_o=0.
- Reads are legal in every state and do not disturb counting.
- A read coincident with clear_i returns the pre-clear value.
- rd_data_o holds its last value when rd_valid_o=0.

Test Plan:
1. Reset, then start_i=1 with event_i=4'b0001 every cycle, CYCLE_LIMIT=30 -> after 30 RUN cycles done_o=1, cycle_o=30, channel 0 reads 30, channels 1-3 read 0, state_o=3.
2. RUN with event_i[1] high for 10 cycles, freeze_i high for 5 cycles with events still asserted, then freeze_i low for 3 cycles -> channel 1 reads 13, cycle_o=13.
3. CNT_W=4, WRAP_MODE=0, 20 events on channel 2 -> reads 15, ovf_o[2]=1. Same stimulus with WRAP_MODE=1 -> reads 4, ovf_o[2]=1.
4. rd_req_i with rd_sel_i=0 held for 3 consecutive cycles during counting with event_i[0]=1 -> three rd_valid_o pulses returning v, v+1, v+2. rd_sel_i=7 with NUM_CH=4 -> rd_data_o=0, rd_valid_o=1.
5. clear_i and start_i asserted together after 12 counted cycles -> next cycle all counters 0, state_o=0. Counting resumes only after the following edge with start_i=1.
6. Drive rst_i low asynchronously mid-RUN between edges -> outputs are 0 immediately, without waiting for a clock edge. After release, state_o=0 until start_i is asserted.
